// File: rtl/robs_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : robs_seq_mult
// Purpose  : Sequential Robertson add/shift multiplier with integrated
//            controller. Retires one multiplier bit per clock; supports
//            two's-complement (signed_mode=1) and unsigned (signed_mode=0)
//            operands selected per operation.
// Ports    : clk          - rising-edge clock
//            reset        - synchronous active-high reset
//            start        - request a multiply (sampled only in IDLE)
//            signed_mode  - 1 = signed operands, 0 = unsigned (with start)
//            multiplier   - operand X (sampled with start)
//            multiplicand - operand Y (sampled with start)
//            busy         - high while RUN or DONE
//            done         - one-cycle pulse when product has just updated
//            product      - last completed 2*WIDTH-bit result
// Revision : 1.0 - initial release
// ============================================================================
module robs_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int QW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [QW-1:0] Q_START = QW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic                 mode_q, mode_d;
  logic [QW-1:0]        q_q, q_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // Iteration datapath
  logic [WIDTH:0]       ext_a;
  logic [WIDTH:0]       ext_y;
  logic [WIDTH:0]       sum;
  logic                 last_iter;
  logic [WIDTH-1:0]     a_next;
  logic [WIDTH-1:0]     x_next;

  always_comb begin
    // Sign extension only when operating on two's-complement operands.
    ext_a     = {mode_q & a_q[WIDTH-1], a_q};
    ext_y     = {mode_q & y_q[WIDTH-1], y_q};
    last_iter = (q_q == '0);
    if (!x_q[0]) begin
      sum = ext_a;
    end else if (last_iter && mode_q) begin
      // Multiplier sign bit carries weight -2^(WIDTH-1): subtract instead.
      sum = ext_a - ext_y;
    end else begin
      sum = ext_a + ext_y;
    end
    // Arithmetic right shift of {sum, x}: x[0] is retired.
    a_next = sum[WIDTH:1];
    x_next = {sum[0], x_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    a_d       = a_q;
    x_d       = x_q;
    mode_d    = mode_q;
    q_d       = q_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          y_d     = multiplicand;
          x_d     = multiplier;
          a_d     = '0;
          mode_d  = signed_mode;
          q_d     = Q_START;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d = a_next;
        x_d = x_next;
        if (last_iter) begin
          product_d = {a_next, x_next};
          state_d   = S_DONE;
        end else begin
          q_d = q_q - QW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      y_q       <= '0;
      a_q       <= '0;
      x_q       <= '0;
      mode_q    <= 1'b0;
      q_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      a_q       <= a_d;
      x_q       <= x_d;
      mode_q    <= mode_d;
      q_q       <= q_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_robs_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_robs_seq_mult
// Purpose  : Directed self-checking bench for robs_seq_mult, exercising an
//            8-bit and a 4-bit instance with hand-computed products.
// Revision : 1.0 - initial release
// ============================================================================
module tb_robs_seq_mult;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        s8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  x8 = '0, y8 = '0;
  logic        busy8, done8;
  logic [15:0] p8;

  logic        s4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  x4 = '0, y4 = '0;
  logic        busy4, done4;
  logic [7:0]  p4;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  robs_seq_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(s8), .signed_mode(sm8),
    .multiplier(x8), .multiplicand(y8),
    .busy(busy8), .done(done8), .product(p8)
  );

  robs_seq_mult #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(s4), .signed_mode(sm4),
    .multiplier(x4), .multiplicand(y4),
    .busy(busy4), .done(done4), .product(p4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One 8-bit multiply; operands are scrambled right after acceptance.
  task automatic run8(input logic sm, input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] exp, input string tag);
    int n;
    int bcnt;
    logic stable;
    logic [15:0] prev;
    prev = p8;
    s8 = 1'b1; sm8 = sm; x8 = x; y8 = y;
    tick();
    s8 = 1'b0; sm8 = ~sm; x8 = ~x; y8 = y + 8'd1;
    n = 0;
    bcnt = busy8 ? 1 : 0;
    stable = 1'b1;
    while (!done8 && n < 20) begin
      tick();
      n++;
      if (busy8) bcnt++;
      if (!done8 && p8 !== prev) stable = 1'b0;
    end
    chk({tag, " latency"}, n, 8);
    chk({tag, " product"}, {16'd0, p8}, {16'd0, exp});
    chk({tag, " product stable"}, {31'd0, stable}, 32'd1);
    tick();
    chk({tag, " done pulse width"}, {31'd0, done8}, 32'd0);
    chk({tag, " busy falls"}, {31'd0, busy8}, 32'd0);
    chk({tag, " busy cycles"}, bcnt, 9);
  endtask

  // One 4-bit multiply; returns one cycle after done so the next call hits
  // the minimum start spacing.
  task automatic run4(input logic sm, input logic [3:0] x, input logic [3:0] y,
                      input logic [7:0] exp, input string tag);
    int n;
    s4 = 1'b1; sm4 = sm; x4 = x; y4 = y;
    tick();
    s4 = 1'b0; x4 = ~x; y4 = ~y;
    n = 0;
    while (!done4 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, n, 4);
    chk({tag, " product"}, {24'd0, p4}, {24'd0, exp});
    tick();
    chk({tag, " idle"}, {31'd0, busy4}, 32'd0);
  endtask

  initial begin
    int dones;
    logic b9, b10;

    reset = 1'b1;
    tick();
    tick();
    chk("reset busy8", {31'd0, busy8}, 32'd0);
    chk("reset done8", {31'd0, done8}, 32'd0);
    chk("reset product8", {16'd0, p8}, 32'd0);
    chk("reset busy4", {31'd0, busy4}, 32'd0);
    chk("reset product4", {24'd0, p4}, 32'd0);
    reset = 1'b0;
    tick();

    run8(1'b1, 8'hFD, 8'h05, 16'hFFF1, "s -3x5");
    run8(1'b1, 8'h80, 8'h80, 16'h4000, "s -128x-128");
    run8(1'b1, 8'h7F, 8'h80, 16'hC080, "s 127x-128");
    run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u 255x255");
    run8(1'b1, 8'hFF, 8'hFF, 16'h0001, "s -1x-1");

    // start held for 20 edges: re-accepted only after busy falls
    s8 = 1'b1; sm8 = 1'b1; x8 = 8'd7; y8 = 8'd6;
    dones = 0; b9 = 1'b0; b10 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done8) dones++;
      if (i == 9)  b9 = busy8;
      if (i == 10) b10 = busy8;
    end
    s8 = 1'b0;
    chk("hold done count", dones, 2);
    chk("hold busy gap", {31'd0, b9}, 32'd0);
    chk("hold reaccept", {31'd0, b10}, 32'd1);
    chk("hold product", {16'd0, p8}, 32'h002A);
    tick();
    chk("hold idle", {31'd0, busy8}, 32'd0);

    // reset during RUN aborts
    s8 = 1'b1; sm8 = 1'b1; x8 = 8'd10; y8 = 8'd10;
    tick();
    s8 = 1'b0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done8) dones++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort no done", dones, 0);
    chk("abort done", {31'd0, done8}, 32'd0);
    chk("abort busy", {31'd0, busy8}, 32'd0);
    chk("abort product", {16'd0, p8}, 32'd0);
    run8(1'b1, 8'd2, 8'd3, 16'h0006, "s 2x3");

    // 4-bit instance, back-to-back at minimum spacing
    run4(1'b1, 4'h8, 4'h7, 8'hC8, "w4 s -8x7");
    run4(1'b0, 4'hF, 4'hF, 8'hE1, "w4 u 15x15");
    run4(1'b1, 4'h3, 4'hE, 8'hFA, "w4 s 3x-2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
